// File: rtl/fp32_to_int_converter.sv
// fp32_to_int_converter
//   Four-stage pipelined IEEE-754 single-precision to signed 32-bit integer
//   converter. Shares the valid framing and 2-bit status code of the FPU and
//   adds output backpressure. Each stage holds while the output is stalled.
//
//   Stages: S1 unpack/classify, S2 range check, S3 align (and optional
//   rounding), S4 sign/saturate/status into the output registers.
//
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-low reset
//     a        in   float operand {sign, exp[7:0], frac[22:0]}
//     arg_vld  in   operand valid
//     arg_rdy  out  operand can be accepted this cycle (combinational)
//     result   out  signed integer result
//     state    out  status: OK=00, NAN=01, INF=10, NUL=11
//     res_vld  out  result/state valid
//     res_rdy  in   consumer accepts result
//
//   Build option: define FP2INT_RNE_EN to round to nearest-even instead of
//   truncating toward zero. Latency is 4 cycles either way.

module fp32_to_int_converter #(
    parameter int unsigned STAGES = 4,
    parameter int unsigned INT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      a,
    input  logic             arg_vld,
    output logic             arg_rdy,
    output logic [INT_W-1:0] result,
    output logic [1:0]       state,
    output logic             res_vld,
    input  logic             res_rdy
);

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned FRAC_W = 23;
    localparam int unsigned MANT_W = FRAC_W + 1;
    localparam int unsigned SH_W   = 5;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_NAN = 2'b01;
    localparam logic [1:0] ST_INF = 2'b10;
    localparam logic [1:0] ST_NUL = 2'b11;

    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

    // Depth and width are architectural constants of this block.
    if (STAGES != 4 || INT_W != 32) begin : g_bad_cfg
        $error("fp32_to_int_converter: STAGES must be 4 and INT_W must be 32");
    end

    // ------------------------------------------------------------------
    // Handshake: a stalled output freezes the whole pipe.
    // ------------------------------------------------------------------
    logic stall_c;
    logic adv_c;

    assign stall_c = res_vld & ~res_rdy;
    assign adv_c   = ~stall_c;
    assign arg_rdy = ~stall_c;

    // ------------------------------------------------------------------
    // S1: unpack and classify.
    // ------------------------------------------------------------------
    logic              a_sign_c;
    logic [EXP_W-1:0]  a_exp_c;
    logic [FRAC_W-1:0] a_frac_c;

    assign a_sign_c = a[31];
    assign a_exp_c  = a[30:23];
    assign a_frac_c = a[22:0];

    logic              s1_vld;
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [MANT_W-1:0] s1_mant;
    logic              s1_nan;
    logic              s1_inf;

    // Zero and denormal inputs get a zero mantissa so they fall out as 0 later.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_vld  <= 1'b0;
            s1_sign <= 1'b0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_nan  <= 1'b0;
            s1_inf  <= 1'b0;
        end else if (adv_c) begin
            s1_vld  <= arg_vld;
            s1_sign <= a_sign_c;
            s1_exp  <= a_exp_c;
            s1_mant <= (a_exp_c == '0) ? '0 : {1'b1, a_frac_c};
            s1_nan  <= (a_exp_c == '1) && (a_frac_c != '0);
            s1_inf  <= (a_exp_c == '1) && (a_frac_c == '0);
        end
    end

    // ------------------------------------------------------------------
    // S2: unbiased exponent, overflow detect, shift direction/amount.
    // ------------------------------------------------------------------
    logic signed [8:0] s2_e_c;
    logic signed [8:0] s2_rsh_c;
    logic              s2_min_int_c;
    logic              s2_ovf_c;
    logic              s2_shl_c;
    logic [SH_W-1:0]   s2_shamt_c;

    assign s2_e_c       = $signed({1'b0, s1_exp}) - 9'sd127;
    assign s2_rsh_c     = 9'sd23 - s2_e_c;
    // -2^31 is the one magnitude of 2^31 that still fits.
    assign s2_min_int_c = s1_sign && (s1_exp == 8'd158) &&
                          (s1_mant == {1'b1, {FRAC_W{1'b0}}});
    assign s2_ovf_c     = (s2_e_c >= 9'sd31) && !s2_min_int_c;
    assign s2_shl_c     = (s2_e_c >= 9'sd23);

    // Right shifts clamp at 25: 24 still leaves the leading one as guard
    // (values in [0.5,1)), 25 and beyond only contribute sticky.
    always_comb begin
        s2_shamt_c = '0;
        if (s2_shl_c) begin
            if (s2_e_c <= 9'sd31) begin
                s2_shamt_c = SH_W'(s2_e_c - 9'sd23);
            end
        end else if (s2_rsh_c > 9'sd25) begin
            s2_shamt_c = SH_W'(25);
        end else begin
            s2_shamt_c = SH_W'(s2_rsh_c);
        end
    end

    logic              s2_vld;
    logic              s2_sign;
    logic [MANT_W-1:0] s2_mant;
    logic              s2_nan;
    logic              s2_inf;
    logic              s2_ovf;
    logic              s2_shl;
    logic [SH_W-1:0]   s2_shamt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_vld   <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mant  <= '0;
            s2_nan   <= 1'b0;
            s2_inf   <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_shl   <= 1'b0;
            s2_shamt <= '0;
        end else if (adv_c) begin
            s2_vld   <= s1_vld;
            s2_sign  <= s1_sign;
            s2_mant  <= s1_mant;
            s2_nan   <= s1_nan;
            s2_inf   <= s1_inf;
            s2_ovf   <= s2_ovf_c;
            s2_shl   <= s2_shl_c;
            s2_shamt <= s2_shamt_c;
        end
    end

    // ------------------------------------------------------------------
    // S3: align the mantissa to an unsigned integer magnitude.
    // ------------------------------------------------------------------
    logic [INT_W-1:0] s3_mag_l_c;
    logic [INT_W-1:0] s3_mag_r_c;
    logic [INT_W-1:0] s3_mag_c;

    assign s3_mag_l_c = {{(INT_W-MANT_W){1'b0}}, s2_mant} << s2_shamt;

`ifdef FP2INT_RNE_EN
    // Shift into a double-width window: the lower half holds guard + sticky.
    logic [2*MANT_W-1:0] s3_win_c;
    logic [INT_W-1:0]    s3_trunc_c;
    logic                s3_guard_c;
    logic                s3_sticky_c;
    logic                s3_rnd_c;

    assign s3_win_c    = {s2_mant, {MANT_W{1'b0}}} >> s2_shamt;
    assign s3_trunc_c  = {{(INT_W-MANT_W){1'b0}}, s3_win_c[2*MANT_W-1:MANT_W]};
    assign s3_guard_c  = s3_win_c[MANT_W-1];
    assign s3_sticky_c = |s3_win_c[MANT_W-2:0];
    assign s3_rnd_c    = s3_guard_c & (s3_sticky_c | s3_trunc_c[0]);
    assign s3_mag_r_c  = s3_trunc_c + {{(INT_W-1){1'b0}}, s3_rnd_c};
`else
    // A shift of 24 or more leaves nothing, which covers |x| < 1.
    assign s3_mag_r_c  = {{(INT_W-MANT_W){1'b0}}, s2_mant >> s2_shamt};
`endif

    assign s3_mag_c = s2_shl ? s3_mag_l_c : s3_mag_r_c;

    logic             s3_vld;
    logic             s3_sign;
    logic             s3_nan;
    logic             s3_inf;
    logic             s3_ovf;
    logic [INT_W-1:0] s3_mag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s3_vld  <= 1'b0;
            s3_sign <= 1'b0;
            s3_nan  <= 1'b0;
            s3_inf  <= 1'b0;
            s3_ovf  <= 1'b0;
            s3_mag  <= '0;
        end else if (adv_c) begin
            s3_vld  <= s2_vld;
            s3_sign <= s2_sign;
            s3_nan  <= s2_nan;
            s3_inf  <= s2_inf;
            s3_ovf  <= s2_ovf;
            s3_mag  <= s3_mag_c;
        end
    end

    // ------------------------------------------------------------------
    // S4: apply sign, saturate, and pick the status code.
    // ------------------------------------------------------------------
    logic [INT_W-1:0] result_nxt_c;
    logic [1:0]       state_nxt_c;

    always_comb begin
        result_nxt_c = '0;
        state_nxt_c  = ST_OK;
        if (s3_nan) begin
            result_nxt_c = '0;
            state_nxt_c  = ST_NAN;
        end else if (s3_inf || s3_ovf) begin
            result_nxt_c = s3_sign ? INT_MIN : INT_MAX;
            state_nxt_c  = ST_INF;
        end else if (s3_mag == '0) begin
            result_nxt_c = '0;
            state_nxt_c  = ST_NUL;
        end else begin
            result_nxt_c = s3_sign ? (~s3_mag + {{(INT_W-1){1'b0}}, 1'b1}) : s3_mag;
            state_nxt_c  = ST_OK;
        end
    end

    // Bubbles leave result/state untouched so the bus only moves on real data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            res_vld <= 1'b0;
            result  <= '0;
            state   <= ST_OK;
        end else if (adv_c) begin
            res_vld <= s3_vld;
            if (s3_vld) begin
                result <= result_nxt_c;
                state  <= state_nxt_c;
            end
        end
    end

endmodule
